// File: rtl/color_pkg.sv
// Shared types and the black-and-white palette for the Mandelbrot color stage.
package color_pkg;

    typedef logic [7:0] iter_t;

    typedef struct packed {
        logic [7:0] R;
        logic [7:0] G;
        logic [7:0] B;
    } rgb_t;

    localparam logic [23:0] RGB_BLACK = 24'h000000;

    // Points inside the set are black; escaping points get a grey ramp by iteration count.
    function automatic rgb_t bnw_color(input iter_t it, input logic inset);
        rgb_t c;
        if (inset) c = rgb_t'(RGB_BLACK);
        else       c = '{R: it, G: it, B: it};
        return c;
    endfunction

endpackage

// File: rtl/color_arbiter_if.sv
// Core-result request bus and framebuffer pixel bus seen by color_arbiter.
interface color_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 17
);
    import color_pkg::*;

    logic [N_REQ-1:0]             req_valid;
    iter_t [N_REQ-1:0]            req_iter;
    logic [N_REQ-1:0]             req_inset;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]             req_ready;

    logic                         out_valid;
    rgb_t                         out_rgb;
    logic [ADDR_W-1:0]            out_addr;
    logic                         out_ready;

    modport slave (
        input  req_valid, req_iter, req_inset, req_addr, out_ready,
        output req_ready, out_valid, out_rgb, out_addr
    );

    modport master (
        output req_valid, req_iter, req_inset, req_addr, out_ready,
        input  req_ready, out_valid, out_rgb, out_addr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic          found;
    int            j;

    always_comb begin
        grant     = '0;
        grant_idx = ptr_q;
        found     = 1'b0;
        j         = 0;
        for (int k = 1; k <= N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = IW'(j);
            end
        end
        if (en && found) grant[grant_idx] = 1'b1;
    end

    // Reset pointer sits at the top so core 0 wins first.
    always_ff @(posedge clk) begin
        if (!nrst)            ptr_q <= IW'(N - 1);
        else if (en && |req)  ptr_q <= grant_idx;
    end

endmodule

// File: rtl/color_arbiter.sv
// Shares one color conversion among N_REQ iteration cores and feeds the framebuffer writer.
module color_arbiter
    import color_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int ADDR_W       = 17,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            clear,
    color_arbiter_if.slave  bus,
    output logic            frame_done,
    output logic            busy
);
    localparam int IW    = $clog2(N_REQ);
    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIXELS - 1);

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    logic             can_accept, en, xfer, hs;

    logic              out_valid_q, out_valid_d;
    rgb_t              out_rgb_q, out_rgb_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    // Gating with nrst keeps cores from seeing ready while reset discards the output.
    assign can_accept = !out_valid_q || bus.out_ready;
    assign en         = can_accept && nrst;
    assign xfer       = |grant;
    assign hs         = out_valid_q && bus.out_ready;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .nrst      (nrst),
        .req       (bus.req_valid),
        .en        (en),
        .grant     (grant),
        .grant_idx (gidx)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_rgb_d   = out_rgb_q;
        out_addr_d  = out_addr_q;
        if (can_accept) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_rgb_d  = bnw_color(bus.req_iter[gidx], bus.req_inset[gidx]);
                out_addr_d = bus.req_addr[gidx];
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (hs) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            done_d = (cnt_q == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            out_valid_q <= 1'b0;
            out_rgb_q   <= rgb_t'(RGB_BLACK);
            out_addr_q  <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_rgb_q   <= out_rgb_d;
            out_addr_q  <= out_addr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rgb   = out_rgb_q;
    assign bus.out_addr  = out_addr_q;
    assign frame_done    = done_q;
    assign busy          = out_valid_q || (|bus.req_valid);

endmodule

// File: tb/tb_color_arbiter.sv
// Directed bench for color_arbiter: reset, mapping, round robin, backpressure, frame, fairness.
module tb_color_arbiter;
    import color_pkg::*;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 17;

    logic clk = 1'b0;
    logic nrst, clear, frame_done, busy;
    int   nvec = 0;
    int   nmis = 0;

    always #5 clk = ~clk;

    color_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) bus ();

    color_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .FRAME_PIXELS(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .clear      (clear),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cores();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_iter[i]  = 8'(16 * (i + 1));
            bus.req_inset[i] = 1'b0;
            bus.req_addr[i]  = ADDR_W'(10 + i);
        end
    endtask

    logic [7:0]  it;
    logic [3:0]  sparse_exp [8];

    initial begin
        sparse_exp = '{4'b1000, 4'b1000, 4'b0010, 4'b1000,
                       4'b0010, 4'b1000, 4'b0010, 4'b1000};
        nrst          = 1'b0;
        clear         = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = 4'hF;
        load_cores();

        // reset with everyone requesting
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_done",  32'(frame_done),    32'd0);
        chk("rst_rgb",   32'(bus.out_rgb),   32'h0);
        chk("rst_addr",  32'(bus.out_addr),  32'h0);

        // round robin from core 0
        nrst = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
            step();
            it = 8'(16 * ((k % 4) + 1));
            chk("rr_valid", 32'(bus.out_valid), 32'd1);
            chk("rr_addr",  32'(bus.out_addr),  32'(10 + (k % 4)));
            chk("rr_rgb",   32'(bus.out_rgb),   32'({it, it, it}));
        end

        // mapping through core 2 alone
        bus.req_valid    = 4'b0100;
        bus.req_iter[2]  = 8'h5A;
        bus.req_addr[2]  = ADDR_W'(100);
        #1;
        chk("map_ready", 32'(bus.req_ready), 32'b0100);
        step();
        chk("map_rgb",  32'(bus.out_rgb),  32'h5A5A5A);
        chk("map_addr", 32'(bus.out_addr), 32'd100);
        bus.req_inset[2] = 1'b1;
        bus.req_iter[2]  = 8'hFF;
        #1;
        chk("inset_ready", 32'(bus.req_ready), 32'b0100);
        step();
        chk("inset_rgb",  32'(bus.out_rgb),  32'h000000);
        chk("inset_addr", 32'(bus.out_addr), 32'd100);
        bus.req_valid = 4'b0000;
        step();
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_busy",  32'(busy),          32'd0);

        // backpressure, pointer now at core 2
        load_cores();
        bus.req_valid = 4'hF;
        #1;
        chk("bp_ready0", 32'(bus.req_ready), 32'b1000);
        step();
        chk("bp_addr0", 32'(bus.out_addr), 32'd13);
        bus.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_busy",  32'(busy),          32'd1);
            step();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_addr",  32'(bus.out_addr),  32'd13);
            chk("bp_rgb",   32'(bus.out_rgb),   32'h404040);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_refill_ready", 32'(bus.req_ready), 32'b0001);
        step();
        chk("bp_refill_addr", 32'(bus.out_addr), 32'd10);
        chk("bp_refill_rgb",  32'(bus.out_rgb),  32'h101010);

        // frame counting from a cleared counter, core 1 streaming
        bus.req_valid = 4'b0000;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_done", 32'(frame_done), 32'd0);
        bus.req_valid = 4'b0010;
        for (int s = 1; s <= 29; s++) begin
            clear = (s == 17) || (s == 20);
            step();
            chk($sformatf("frame_done_s%0d", s), 32'(frame_done), 32'((s == 9) || (s == 28)));
        end
        clear = 1'b0;

        // sparse fairness: core 3 steady, core 1 every other cycle
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = {1'b1, 1'b0, (c % 2 == 0), 1'b0};
            #1;
            chk($sformatf("sparse_ready_c%0d", c), 32'(bus.req_ready), 32'(sparse_exp[c]));
            step();
            chk($sformatf("sparse_addr_c%0d", c), 32'(bus.out_addr),
                (sparse_exp[c] == 4'b1000) ? 32'd13 : 32'd11);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
